hex_display_scanner: RTL and testbench

//  Parametrised N-digit hex display driver for the FPGA controller. Latches a 4*N-bit value on a

---
 rtl/seven_seg_pkg.sv | 48 ++++
 rtl/scan_timer.sv | 52 +++++
 rtl/hex_display_scanner.sv | 124 ++++++++++++
 tb/tb_hex_display_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment pattern table and hex decoder.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Scan timing for the multiplexed display: slot prescaler, digit index,
// dead-time flag and blink phase.
module scan_timer #(
    parameter int SCAN_DIV   = 12500,
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 250,
    parameter int DEAD_CYC   = 64,
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IDX_W-1:0] idx,
    output logic             dead,
    output logic             blink_on
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PRE_W-1:0] presc;
    logic [BLK_W-1:0] blink_cnt;
    logic             tick;

    assign tick = (presc == PRE_W'(SCAN_DIV - 1));
    assign dead = (presc < PRE_W'(DEAD_CYC));

    // Blink phase is counted in slot ticks so it stays locked to the scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (tick) begin
            presc <= '0;
            if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                idx <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
            if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// N-digit hex display driver: latched value, static per-digit segment buses
// and a time-multiplexed seg/an pair with blanking, blink and dead time.
module hex_display_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 12500,
    parameter int DEAD_CYC   = 64,
    parameter int BLINK_DIV  = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] value_r;
    logic [NUM_DIGITS-1:0]   dp_r;
    logic [NUM_DIGITS-1:0]   blink_r;
    logic [IDX_W-1:0]        idx;
    logic                    dead;
    logic                    blink_on;

    logic [6:0]              dig_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   dig_dp;
    logic [7*NUM_DIGITS-1:0] hex_next;
    logic [6:0]              mux_seg;
    logic                    mux_dp;
    logic [NUM_DIGITS-1:0]   an_next;

    scan_timer #(
        .SCAN_DIV   (SCAN_DIV),
        .NUM_DIGITS (NUM_DIGITS),
        .BLINK_DIV  (BLINK_DIV),
        .DEAD_CYC   (DEAD_CYC)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .idx      (idx),
        .dead     (dead),
        .blink_on (blink_on)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= '0;
            dp_r    <= '0;
            blink_r <= '0;
        end else if (load) begin
            value_r <= value;
            dp_r    <= dp_in;
            blink_r <= blink_en;
        end
    end

    // Walk from the most significant digit down; zeros stay blank until the first nonzero.
    always_comb begin
        logic       seen_nz;
        logic [3:0] nib;
        logic       lz;
        logic       off;
        seen_nz  = 1'b0;
        nib      = '0;
        lz       = 1'b0;
        off      = 1'b0;
        dig_seg  = '{default: SEG_BLANK};
        dig_dp   = '1;
        hex_next = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = value_r[4*i +: 4];
            if (nib != 4'h0) begin
                seen_nz = 1'b1;
            end
            lz  = blank_lz && !seen_nz && (i != 0);
            off = blink_r[i] && !blink_on;
            dig_seg[i]         = (lz || off) ? SEG_BLANK : hex_to_seg(nib);
            dig_dp[i]          = off ? 1'b1 : ~dp_r[i];
            hex_next[7*i +: 7] = dig_seg[i];
        end
    end

    always_comb begin
        mux_seg = SEG_BLANK;
        mux_dp  = 1'b1;
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                mux_seg = dig_seg[i];
                mux_dp  = dig_dp[i];
                if (!dead) begin
                    an_next[i] = 1'b0;
                end
            end
        end
    end

    // Anodes and segments share one register stage so they never skew apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex_out <= '1;
            dp_out  <= '1;
            seg     <= SEG_BLANK;
            dp      <= 1'b1;
            an      <= '1;
        end else begin
            hex_out <= hex_next;
            dp_out  <= dig_dp;
            seg     <= mux_seg;
            dp      <= mux_dp;
            an      <= an_next;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed self-checking bench for hex_display_scanner with a short scan slot
// (8 clocks, 2 dead) and a 2-slot blink half-period.
module tb_hex_display_scanner;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BD = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blink_en = '0;
    logic          blank_lz = 1'b0;
    logic [27:0]   hex_out;
    logic [3:0]    dp_out;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [6:0] expDigit [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};

    hex_display_scanner #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .DEAD_CYC   (DC),
        .BLINK_DIV  (BD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value    (value),
        .dp_in    (dp_in),
        .blink_en (blink_en),
        .blank_lz (blank_lz),
        .hex_out  (hex_out),
        .dp_out   (dp_out),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Edges since the last reset release; cyc=k means k edges have passed.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic lz);
        @(negedge clk);
        value    = v;
        dp_in    = d;
        blink_en = b;
        blank_lz = lz;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic waitCycle(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  j;
        int  slot;
        bit  lit;
        bit  blinkOff;
        logic [3:0] expAn;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_hex", hex_out, 28'hFFFFFFF);
        checkOutput("rst_dpout", dp_out, 4'hF);
        checkOutput("rst_seg", seg, 7'h7F);
        checkOutput("rst_dp", dp, 1'b1);
        checkOutput("rst_an", an, 4'hF);
        rst = 1'b0;

        // Static decode with two-cycle latency
        applyStimulus(16'h12AF, 4'b0000, 4'b0000, 1'b0);
        checkOutput("latency_hold", hex_out, {4{7'h40}});
        @(negedge clk);
        checkOutput("t1_hex", hex_out, {7'h79, 7'h24, 7'h08, 7'h0E});
        checkOutput("t1_dpout", dp_out, 4'hF);

        // Leading-zero blanking
        applyStimulus(16'h0050, 4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("lz_0050", hex_out, {7'h7F, 7'h7F, 7'h12, 7'h40});
        applyStimulus(16'h0000, 4'b0100, 4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("lz_0000", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        checkOutput("lz_dp_kept", dp_out, 4'b1011);
        blank_lz = 1'b0;
        @(negedge clk);
        checkOutput("lz_live_off", hex_out, {4{7'h40}});
        applyStimulus(16'h1000, 4'b0000, 4'b0000, 1'b1);
        @(negedge clk);
        checkOutput("lz_1000", hex_out, {7'h79, 7'h40, 7'h40, 7'h40});

        // Scan and blink from a known reset-aligned frame
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        value    = 16'h12AF;
        dp_in    = 4'b0001;
        blink_en = 4'b0001;
        blank_lz = 1'b0;
        load     = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 2; k <= 60; k++) begin
            waitCycle(k);
            j        = k - 1;
            slot     = (j / SD) % N;
            lit      = (j % SD) >= DC;
            expAn    = lit ? ~(4'b0001 << slot) : 4'b1111;
            blinkOff = ((j / (SD * BD)) % 2) == 1;
            checkOutput("scan_an", an, expAn);
            if (lit) begin
                checkOutput("scan_seg", seg, expDigit[slot]);
                checkOutput("scan_dp", dp, (slot == 0) ? 1'b0 : 1'b1);
            end
            checkOutput("blink_seg0", hex_out[6:0], blinkOff ? 7'h7F : 7'h0E);
            checkOutput("blink_dp0", dp_out[0], blinkOff ? 1'b1 : 1'b0);
            checkOutput("blink_steady", hex_out[27:7], {7'h79, 7'h24, 7'h08});
        end

        // Asynchronous reset in the middle of a lit slot
        #2 rst = 1'b1;
        #1;
        checkOutput("async_hex", hex_out, 28'hFFFFFFF);
        checkOutput("async_dpout", dp_out, 4'hF);
        checkOutput("async_seg", seg, 7'h7F);
        checkOutput("async_dp", dp, 1'b1);
        checkOutput("async_an", an, 4'hF);
        @(negedge clk);
        rst      = 1'b0;
        value    = '0;
        dp_in    = '0;
        blink_en = '0;
        waitCycle(2);
        checkOutput("post_rst_dead", an, 4'b1111);
        waitCycle(3);
        checkOutput("post_rst_an", an, 4'b1110);
        checkOutput("post_rst_seg", seg, 7'h40);
        checkOutput("post_rst_dp", dp, 1'b1);
        checkOutput("post_rst_hex", hex_out, {4{7'h40}});
        checkOutput("post_rst_dpout", dp_out, 4'hF);

        // Load landing on the same edge as the slot wrap
        waitCycle(15);
        value = 16'h0B00;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checkOutput("wrap_old_seg", seg, 7'h40);
        checkOutput("wrap_old_an", an, 4'b1101);
        @(negedge clk);
        checkOutput("wrap_new_seg", seg, 7'h03);
        checkOutput("wrap_dead_an", an, 4'b1111);
        waitCycle(19);
        checkOutput("wrap_lit_an", an, 4'b1011);
        checkOutput("wrap_lit_seg", seg, 7'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
